aux_uart_boot_loader: RTL and testbench

Boot loader that sits upstream of the MCU core and its program memory. It receives a program image over the auxiliary UART pin (gpio[31], used when BOOT_FROM_AUX_UART is defined) and writes 32-bit words into instruction/data RAM through a write port. It holds the CPU in reset until the image has loaded completely and correctly, then releases it.

---
 rtl/aux_boot_pkg.sv | 26 ++
 rtl/aux_uart_rx.sv | 91 +++++++++
 rtl/aux_uart_boot_loader.sv | 152 +++++++++++++++
 tb/tb_aux_uart_boot_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_boot_pkg.sv
// Shared types and constants for the auxiliary UART boot loader.
// BOOT_CHECKSUM_EN adds the trailing checksum word state.
package aux_boot_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 50000000 / 115200;
    localparam int LEN_WIDTH            = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LEN,
        ST_DATA,
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/aux_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// centre sampling, one-cycle byte_valid / frame_err pulses.
module aux_uart_rx
    import aux_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             ferr_q;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q && !rx_s) state_q <= RX_START;
                end
                RX_START: begin
                    // Line back high at mid start bit means a glitch, not a frame.
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s) valid_q <= 1'b1;
                        else      ferr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_data_o  = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/aux_uart_boot_loader.sv
// Loads a length-prefixed program image from the aux UART into RAM and holds
// the CPU in reset until done. BOOT_CHECKSUM_EN enables the trailing checksum.
module aux_uart_boot_loader
    import aux_boot_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  uart_rx,
    input  logic                  boot_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_resetb,
    output logic                  boot_busy,
    output logic                  boot_done,
    output logic                  boot_error
);

    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam boot_state_t ST_AFTER_DATA = ST_DONE;
`endif

    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  rx_ferr;

    boot_state_t           state_q;
    logic [LEN_WIDTH-9:0]  shift_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   wr_cnt_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic                  cpu_resetb_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]           sum_q;
`endif
    logic [LEN_WIDTH-1:0]  word_d;

    aux_uart_rx #(
        .CLKS_PER_BIT(CLK_FREQUENCY / BAUD_RATE)
    ) u_rx (
        .clk_i       (clk),
        .rst_ni      (resetb),
        .rx_i        (uart_rx),
        .byte_data_o (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    // Little-endian: the newest byte lands in the top lane.
    assign word_d = {rx_byte, shift_q};

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_INIT;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            len_q        <= '0;
            wr_cnt_q     <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            cpu_resetb_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            we_q         <= 1'b0;
            busy_q       <= !(state_q inside {ST_INIT, ST_DONE, ST_ERROR});
            done_q       <= (state_q == ST_DONE);
            error_q      <= (state_q == ST_ERROR);
            cpu_resetb_q <= (state_q == ST_DONE);
`ifdef BOOT_CHECKSUM_EN
            if (we_q) sum_q <= sum_q + wdata_q;
`endif
            case (state_q)
                ST_INIT: state_q <= boot_enable ? ST_LEN : ST_DONE;
                ST_LEN: begin
                    if (rx_ferr) begin
                        state_q <= ST_ERROR;
                    end else if (rx_valid) begin
                        shift_q    <= word_d[LEN_WIDTH-1:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if ({1'b0, word_d} > MAX_WORDS) begin
                                state_q <= ST_ERROR;
                            end else if (word_d == '0) begin
                                state_q <= ST_AFTER_DATA;
                            end else begin
                                len_q   <= word_d[ADDR_WIDTH:0];
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) begin
                        state_q <= ST_ERROR;
                    end else if (we_q) begin
                        // Address advances only between words so it never wraps after the last.
                        wr_cnt_q <= wr_cnt_q + (ADDR_WIDTH + 1)'(1);
                        if (wr_cnt_q + (ADDR_WIDTH + 1)'(1) == len_q) state_q <= ST_AFTER_DATA;
                        else waddr_q <= waddr_q + ADDR_WIDTH'(1);
                    end else if (rx_valid) begin
                        shift_q    <= word_d[LEN_WIDTH-1:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= word_d;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_ferr) begin
                        state_q <= ST_ERROR;
                    end else if (rx_valid) begin
                        shift_q    <= word_d[LEN_WIDTH-1:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) state_q <= (word_d == sum_q) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                default: state_q <= state_q;
            endcase
        end
    end

    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_resetb = cpu_resetb_q;
    assign boot_busy  = busy_q;
    assign boot_done  = done_q;
    assign boot_error = error_q;

endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Bench for aux_uart_boot_loader: table of images plus hand-written corner
// sequences; memory writes checked against a queue of expected writes.
module tb_aux_uart_boot_loader;

    localparam int AW  = 12;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          uart_rx = 1'b1;
    logic          boot_enable = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_resetb;
    logic          boot_busy;
    logic          boot_done;
    logic          boot_error;

    always #10 clk = ~clk;

    aux_uart_boot_loader #(
        .CLK_FREQUENCY(50000000),
        .BAUD_RATE    (3125000),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .uart_rx    (uart_rx),
        .boot_enable(boot_enable),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_resetb (cpu_resetb),
        .boot_busy  (boot_busy),
        .boot_done  (boot_done),
        .boot_error (boot_error)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        string        name;
        logic [31:0]  len;
        int unsigned  nw;
        logic [31:0]  w [3];
        logic [31:0]  csum_delta;
        logic         exp_done;
        logic         exp_err;
        int unsigned  exp_wr;
        logic [31:0]  exp_waddr;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_seen = 0;
    wr_t         exp_q[$];
    wr_t         exp_w;
    vec_t        vecs[8];
    int          nvec = 0;
    logic [31:0] sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetb === 1'b1 && mem_we === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write",
                         mem_waddr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_addr", 32'(mem_waddr), 32'(exp_w.addr));
                check("write_data", mem_wdata, exp_w.data);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(CPB);
        end
        uart_rx = stop_bit;
        wait_clks(CPB);
        uart_rx = 1'b1;
        wait_clks(CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset(input logic be);
        resetb      = 1'b0;
        boot_enable = be;
        uart_rx     = 1'b1;
        wait_clks(3);
        wr_seen = 0;
        resetb  = 1'b1;
    endtask

    task automatic add_vec(input string nm, input logic [31:0] len, input int unsigned nw,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] delta, input logic done, input logic err,
                           input int unsigned nwr, input logic [31:0] waddr);
        vecs[nvec].name       = nm;
        vecs[nvec].len        = len;
        vecs[nvec].nw         = nw;
        vecs[nvec].w[0]       = w0;
        vecs[nvec].w[1]       = w1;
        vecs[nvec].w[2]       = w2;
        vecs[nvec].csum_delta = delta;
        vecs[nvec].exp_done   = done;
        vecs[nvec].exp_err    = err;
        vecs[nvec].exp_wr     = nwr;
        vecs[nvec].exp_waddr  = waddr;
        nvec++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_waddr"},  32'(mem_waddr),  32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_cpu_resetb"}, 32'(cpu_resetb), 32'd0);
        check({tag, "_boot_busy"},  32'(boot_busy),  32'd0);
        check({tag, "_boot_done"},  32'(boot_done),  32'd0);
        check({tag, "_boot_error"}, 32'(boot_error), 32'd0);
    endtask

    initial begin
        add_vec("len3",    32'd3,    3, 32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b1, 1'b0, 3, 32'd2);
        add_vec("len4097", 32'd4097, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0, 32'd0);
        add_vec("len0",    32'd0,    0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 0, 32'd0);
        add_vec("len1",    32'd1,    1, 32'hA5A50F0F, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1, 32'd0);
`ifdef BOOT_CHECKSUM_EN
        add_vec("csum_ok",  32'd2, 2, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 1'b1, 1'b0, 2, 32'd1);
        add_vec("csum_bad", 32'd2, 2, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd1, 1'b0, 1'b1, 2, 32'd1);
`endif

        // Outputs while reset is held.
        resetb      = 1'b0;
        boot_enable = 1'b1;
        wait_clks(3);
        check_reset_values("in_reset");

        // Strap low: CPU released by the second clock, nothing written.
        do_reset(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("noboot_cpu_resetb", 32'(cpu_resetb), 32'd1);
        check("noboot_boot_done",  32'(boot_done),  32'd1);
        boot_enable = 1'b1;
        send_word(32'h00000001);
        wait_clks(20);
        check("noboot_writes", 32'(wr_seen),    32'd0);
        check("noboot_busy",   32'(boot_busy),  32'd0);
        check("noboot_error",  32'(boot_error), 32'd0);

        // Table of images.
        for (int v = 0; v < nvec; v++) begin
            do_reset(1'b1);
            wait_clks(4);
            sum = '0;
            send_word(vecs[v].len);
            for (int unsigned i = 0; i < vecs[v].nw; i++) begin
                if (i < vecs[v].exp_wr) exp_q.push_back('{addr: AW'(i), data: vecs[v].w[i]});
                sum = sum + vecs[v].w[i];
                send_word(vecs[v].w[i]);
            end
`ifdef BOOT_CHECKSUM_EN
            send_word(sum + vecs[v].csum_delta);
`endif
            wait_clks(20);
            check({vecs[v].name, "_done"},       32'(boot_done),  32'(vecs[v].exp_done));
            check({vecs[v].name, "_error"},      32'(boot_error), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_cpu_resetb"}, 32'(cpu_resetb), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_busy"},       32'(boot_busy),  32'd0);
            check({vecs[v].name, "_writes"},     32'(wr_seen),    vecs[v].exp_wr);
            check({vecs[v].name, "_waddr"},      32'(mem_waddr),  vecs[v].exp_waddr);
            check({vecs[v].name, "_pending"},    32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // Short low glitch while idle must not produce a byte.
        do_reset(1'b1);
        wait_clks(4);
        uart_rx = 1'b0;
        wait_clks(2);
        uart_rx = 1'b1;
        wait_clks(40);
        check("glitch_busy",   32'(boot_busy), 32'd1);
        check("glitch_writes", 32'(wr_seen),   32'd0);
        exp_q.push_back('{addr: AW'(0), data: 32'hCAFEF00D});
        send_word(32'd1);
        send_word(32'hCAFEF00D);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'hCAFEF00D);
`endif
        wait_clks(20);
        check("glitch_done",   32'(boot_done),  32'd1);
        check("glitch_error",  32'(boot_error), 32'd0);
        check("glitch_writes_after", 32'(wr_seen), 32'd1);

        // Bad stop bit on the second byte of the second data word, then reset mid-image.
        do_reset(1'b1);
        wait_clks(4);
        send_word(32'd2);
        exp_q.push_back('{addr: AW'(0), data: 32'h11223344});
        send_word(32'h11223344);
        send_byte(8'h55, 1'b1);
        check("frame_busy_mid", 32'(boot_busy), 32'd1);
        send_byte(8'h66, 1'b0);
        wait_clks(20);
        check("frame_error",      32'(boot_error), 32'd1);
        check("frame_cpu_resetb", 32'(cpu_resetb), 32'd0);
        check("frame_done",       32'(boot_done),  32'd0);
        check("frame_busy",       32'(boot_busy),  32'd0);
        check("frame_writes",     32'(wr_seen),    32'd1);
        check("frame_waddr",      32'(mem_waddr),  32'd1);
        check("frame_wdata",      mem_wdata,       32'h11223344);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        wait_clks(20);
        check("frame_writes_after", 32'(wr_seen), 32'd1);
        resetb = 1'b0;
        wait_clks(2);
        check_reset_values("mid_reset");
        resetb = 1'b1;
        wait_clks(2);

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
